video_timing_gen: RTL and testbench

- Parametrised raster timing generator and pixel output stage. It is the successor to the fixed 256x256 video block.
- Produces sync, blank and data-enable signals, plus a pixel clock enable.
- Issues pixel fetch coordinates LEAD pixels ahead of display so upstream tile/sprite logic can source colour.
- Expands IN_BITS colour to 8 bits, with an optional white border overlay. Feeds the board video mixer / HDMI path.

---
 rtl/video_timing_gen_if.sv | 35 +++
 rtl/video_timing_gen.sv | 186 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Video output and pixel-fetch signal bundle for video_timing_gen.
// The generator drives everything except the colour inputs sourced by fetch logic.
interface video_timing_gen_if #(
  parameter int IN_BITS = 4
);
  logic               ce_pix;
  logic               hs;
  logic               vs;
  logic               hblank;
  logic               vblank;
  logic               de;
  logic [7:0]         r;
  logic [7:0]         g;
  logic [7:0]         b;
  logic               line_start;
  logic               frame_start;
  logic               pix_req;
  logic [11:0]        pix_x;
  logic [11:0]        pix_y;
  logic [IN_BITS-1:0] r_in;
  logic [IN_BITS-1:0] g_in;
  logic [IN_BITS-1:0] b_in;

  modport master (
    output ce_pix, hs, vs, hblank, vblank, de, r, g, b,
           line_start, frame_start, pix_req, pix_x, pix_y,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  ce_pix, hs, vs, hblank, vblank, de, r, g, b,
           line_start, frame_start, pix_req, pix_x, pix_y,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with LEAD-ahead fetch coordinates and colour expansion.
// Define VIDEO_TESTPAT_EN to add the pattern_en input and the eight-bar test pattern.
module video_timing_gen #(
  parameter int H_DISPLAY = 256,
  parameter int H_FP      = 8,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 16,
  parameter int V_DISPLAY = 256,
  parameter int V_FP      = 8,
  parameter int V_SYNC    = 8,
  parameter int V_BP      = 16,
  parameter int CE_DIV    = 1,
  parameter int LEAD      = 2,
  parameter int IN_BITS   = 4,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic border_en,
`ifdef VIDEO_TESTPAT_EN
  input  logic pattern_en,
`endif
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_DISPLAY + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISPLAY + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [11:0] H_LAST_C    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST_C    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_START_C   = 12'(H_START);
  localparam logic [11:0] V_START_C   = 12'(V_START);
  localparam logic [11:0] H_END_C     = 12'(H_START + H_DISPLAY);
  localparam logic [11:0] V_END_C     = 12'(V_START + V_DISPLAY);
  localparam logic [11:0] H_SYNC_C    = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_C    = 12'(V_SYNC);
  localparam logic [11:0] H_DLAST_C   = 12'(H_DISPLAY - 1);
  localparam logic [11:0] V_DLAST_C   = 12'(V_DISPLAY - 1);
  localparam logic [12:0] H_TOTAL_W   = 13'(H_TOTAL);
  localparam logic [12:0] LEAD_W      = 13'(LEAD);
  localparam logic [3:0]  DIV_LAST    = 4'(CE_DIV - 1);

  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_total_chk
    $error("video_timing_gen: H_TOTAL and V_TOTAL must fit 12-bit counters");
  end
  if (CE_DIV < 1 || CE_DIV > 16 || LEAD < 1 || LEAD > 8 || IN_BITS < 1 || IN_BITS > 8) begin : g_param_chk
    $error("video_timing_gen: CE_DIV, LEAD or IN_BITS out of range");
  end

  function automatic logic [7:0] expand(input logic [IN_BITS-1:0] c);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7-i] = c[IN_BITS-1-(i % IN_BITS)];
    return o;
  endfunction

  logic        run;
  logic [3:0]  div;
  logic        ce;
  logic [11:0] h_count;
  logic [11:0] v_count;

  // run holds ce low on the first edge after release so the first ce sees counters at zero
  assign ce         = run && (div == DIV_LAST);
  assign vid.ce_pix = ce;

  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      div <= '0;
    end else begin
      run <= 1'b1;
      div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (ce) begin
      if (h_count == H_LAST_C) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST_C) ? 12'd0 : v_count + 12'd1;
      end else begin
        h_count <= h_count + 12'd1;
      end
    end
  end

  logic        h_act, v_act, de_n, border_hit, f_act;
  logic [11:0] col, row, fh, fv;
  logic [12:0] fh_sum;

  always_comb begin
    h_act      = (h_count >= H_START_C) && (h_count < H_END_C);
    v_act      = (v_count >= V_START_C) && (v_count < V_END_C);
    de_n       = h_act && v_act;
    col        = h_count - H_START_C;
    row        = v_count - V_START_C;
    border_hit = (col == 12'd0) || (col == H_DLAST_C) || (row == 12'd0) || (row == V_DLAST_C);
    // fetch position runs LEAD pixels ahead and may spill into the following line
    fh_sum     = {1'b0, h_count} + LEAD_W;
    fh         = fh_sum[11:0];
    fv         = v_count;
    if (fh_sum >= H_TOTAL_W) begin
      fh = 12'(fh_sum - H_TOTAL_W);
      fv = (v_count == V_LAST_C) ? 12'd0 : v_count + 12'd1;
    end
    f_act      = (fh >= H_START_C) && (fh < H_END_C) && (fv >= V_START_C) && (fv < V_END_C);
  end

  logic [7:0] src_r, src_g, src_b, r_n, g_n, b_n;

`ifdef VIDEO_TESTPAT_EN
  localparam int BAR_W = (H_DISPLAY >= 8) ? H_DISPLAY / 8 : 1;
  logic [11:0] bar;
  logic [2:0]  bar_idx;
`endif

  always_comb begin
    src_r = expand(vid.r_in);
    src_g = expand(vid.g_in);
    src_b = expand(vid.b_in);
`ifdef VIDEO_TESTPAT_EN
    bar     = col / 12'(BAR_W);
    bar_idx = (bar > 12'd7) ? 3'd7 : bar[2:0];
    if (pattern_en) begin
      src_r = {8{bar_idx[2]}};
      src_g = {8{bar_idx[1]}};
      src_b = {8{bar_idx[0]}};
    end
`endif
    r_n = 8'h00;
    g_n = 8'h00;
    b_n = 8'h00;
    if (de_n) begin
      if (border_en && border_hit) begin
        r_n = 8'hFF;
        g_n = 8'hFF;
        b_n = 8'hFF;
      end else begin
        r_n = src_r;
        g_n = src_g;
        b_n = src_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vid.hs          <= ~HS_POL;
      vid.vs          <= ~VS_POL;
      vid.hblank      <= 1'b1;
      vid.vblank      <= 1'b1;
      vid.de          <= 1'b0;
      vid.r           <= 8'h00;
      vid.g           <= 8'h00;
      vid.b           <= 8'h00;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.pix_req     <= 1'b0;
      vid.pix_x       <= '0;
      vid.pix_y       <= '0;
    end else if (ce) begin
      vid.hs          <= (h_count < H_SYNC_C) ? HS_POL : ~HS_POL;
      vid.vs          <= (v_count < V_SYNC_C) ? VS_POL : ~VS_POL;
      vid.hblank      <= ~h_act;
      vid.vblank      <= ~v_act;
      vid.de          <= de_n;
      vid.r           <= r_n;
      vid.g           <= g_n;
      vid.b           <= b_n;
      vid.line_start  <= (h_count == 12'd0);
      vid.frame_start <= (h_count == 12'd0) && (v_count == 12'd0);
      vid.pix_req     <= f_act;
      if (f_act) begin
        vid.pix_x <= fh - H_START_C;
        vid.pix_y <= fv - V_START_C;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default timing, CE_DIV=3 and a reduced-size raster.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic border_en = 1'b0;
`ifdef VIDEO_TESTPAT_EN
  logic pattern_en = 1'b0;
`endif
  int tests = 0;
  int fails = 0;
  int k = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.IN_BITS(4)) v0 ();
  video_timing_gen_if #(.IN_BITS(4)) v3 ();
  video_timing_gen_if #(.IN_BITS(3)) vs ();

  video_timing_gen u0 (
    .clk(clk), .reset(reset), .border_en(border_en),
`ifdef VIDEO_TESTPAT_EN
    .pattern_en(pattern_en),
`endif
    .vid(v0.master)
  );

  video_timing_gen #(.CE_DIV(3)) u3 (
    .clk(clk), .reset(reset), .border_en(border_en),
`ifdef VIDEO_TESTPAT_EN
    .pattern_en(pattern_en),
`endif
    .vid(v3.master)
  );

  video_timing_gen #(
    .H_DISPLAY(16), .H_FP(2), .H_SYNC(1), .H_BP(0),
    .V_DISPLAY(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IN_BITS(3), .HS_POL(1'b0)
  ) us (
    .clk(clk), .reset(reset), .border_en(border_en),
`ifdef VIDEO_TESTPAT_EN
    .pattern_en(pattern_en),
`endif
    .vid(vs.master)
  );

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({v0.ce_pix, v0.de, v0.hblank, v0.vblank, v0.hs, v0.vs, v0.line_start, v0.frame_start, v0.pix_req} !== 9'b001100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 001100000", {v0.ce_pix, v0.de, v0.hblank, v0.vblank, v0.hs, v0.vs, v0.line_start, v0.frame_start, v0.pix_req});
    end
    tests++;
    if ({v0.r, v0.g, v0.b, v0.pix_x, v0.pix_y} !== 48'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {v0.r, v0.g, v0.b, v0.pix_x, v0.pix_y});
    end
    tests++;
    if ({vs.hs, v3.ce_pix} !== 2'b10) begin
      fails++;
      $display("FAIL reset_hs_pol_low: got %b want 10", {vs.hs, v3.ce_pix});
    end
    reset = 1'b0;
    k = 0;
    step();
    tests++;
    if ({v0.ce_pix, v0.hs} !== 2'b10) begin
      fails++;
      $display("FAIL release_first_clk: got %b want 10", {v0.ce_pix, v0.hs});
    end
    step();
    tests++;
    if ({v0.hs, v0.frame_start, v0.line_start, v0.hblank, v0.vblank, v0.de} !== 6'b111110) begin
      fails++;
      $display("FAIL first_ce_outputs: got %b want 111110", {v0.hs, v0.frame_start, v0.line_start, v0.hblank, v0.vblank, v0.de});
    end
  endtask

  task automatic test_hsync();
    int hs_cnt = 0, ls_cnt = 0, rise1 = -1, rise2 = -1;
    logic prev;
    do_reset();
    prev = v0.hs;
    while (k < 640) begin
      step();
      if (v0.hs) hs_cnt++;
      if (v0.line_start) ls_cnt++;
      if (v0.hs && !prev) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev = v0.hs;
    end
    tests++;
    if (hs_cnt !== 80) begin fails++; $display("FAIL hs_high_count: got %0d want 80", hs_cnt); end
    tests++;
    if (rise1 !== 2) begin fails++; $display("FAIL hs_first_rise: got %0d want 2", rise1); end
    tests++;
    if (rise2 - rise1 !== 320) begin fails++; $display("FAIL hs_period: got %0d want 320", rise2 - rise1); end
    tests++;
    if (ls_cnt !== 2) begin fails++; $display("FAIL line_start_count: got %0d want 2", ls_cnt); end
  endtask

  task automatic test_fetch_colour();
    int first_req = -1, first_de = -1, bad_cmp = 0;
    while (k < 8200) begin
      step();
      if (v0.de !== (!v0.hblank && !v0.vblank)) bad_cmp++;
      if (v0.pix_req && first_req < 0) begin
        first_req = k;
        tests++;
        if ({v0.pix_x, v0.pix_y} !== 24'h0) begin
          fails++;
          $display("FAIL first_req_xy: got %h want 000000", {v0.pix_x, v0.pix_y});
        end
      end
      if (v0.de && first_de < 0) first_de = k;
      if (k == 7737) begin
        tests++;
        if ({v0.hblank, v0.vblank, v0.r, v0.g, v0.b} !== {2'b10, 24'h0}) begin
          fails++;
          $display("FAIL pre_de_blank: got %h want %h", {v0.hblank, v0.vblank, v0.r, v0.g, v0.b}, {2'b10, 24'h0});
        end
      end
      if (k == 7738) begin
        tests++;
        if ({v0.r, v0.g, v0.b} !== 24'hAA33FF) begin
          fails++;
          $display("FAIL colour_expand: got %h want AA33FF", {v0.r, v0.g, v0.b});
        end
      end
      if (k == 7747) border_en = 1'b1;
      if (k == 7748) begin
        tests++;
        if ({v0.r, v0.g, v0.b} !== 24'hFFFFFF) begin
          fails++;
          $display("FAIL border_row0: got %h want FFFFFF", {v0.r, v0.g, v0.b});
        end
      end
      if (k == 7991) begin
        tests++;
        if ({v0.pix_req, v0.pix_x, v0.pix_y} !== {1'b1, 12'd255, 12'd0}) begin
          fails++;
          $display("FAIL last_pix_x: got req=%b x=%0d y=%0d want 1 255 0", v0.pix_req, v0.pix_x, v0.pix_y);
        end
      end
      if (k == 7992) begin
        tests++;
        if ({v0.pix_req, v0.pix_x} !== {1'b0, 12'd255}) begin
          fails++;
          $display("FAIL pix_hold: got req=%b x=%0d want 0 255", v0.pix_req, v0.pix_x);
        end
      end
      if (k == 7993) begin
        tests++;
        if ({v0.de, v0.r, v0.g, v0.b} !== {1'b1, 24'hFFFFFF}) begin
          fails++;
          $display("FAIL border_col255: got %h want 1FFFFFF", {v0.de, v0.r, v0.g, v0.b});
        end
      end
      if (k == 7994) begin
        tests++;
        if ({v0.de, v0.r, v0.g, v0.b} !== 25'h0) begin
          fails++;
          $display("FAIL de_end_black: got %h want 0", {v0.de, v0.r, v0.g, v0.b});
        end
      end
      if (k == 8056) begin
        tests++;
        if ({v0.pix_req, v0.pix_x, v0.pix_y} !== {1'b1, 12'd0, 12'd1}) begin
          fails++;
          $display("FAIL row1_fetch: got req=%b x=%0d y=%0d want 1 0 1", v0.pix_req, v0.pix_x, v0.pix_y);
        end
      end
      if (k == 8058) begin
        tests++;
        if ({v0.r, v0.g, v0.b} !== 24'hFFFFFF) begin
          fails++;
          $display("FAIL border_col0: got %h want FFFFFF", {v0.r, v0.g, v0.b});
        end
      end
      if (k == 8158) begin
        tests++;
        if ({v0.r, v0.g, v0.b} !== 24'hAA33FF) begin
          fails++;
          $display("FAIL border_interior: got %h want AA33FF", {v0.r, v0.g, v0.b});
        end
      end
    end
    border_en = 1'b0;
    tests++;
    if (first_req !== 7736) begin fails++; $display("FAIL first_pix_req: got %0d want 7736", first_req); end
    tests++;
    if (first_de !== 7738) begin fails++; $display("FAIL first_de: got %0d want 7738", first_de); end
    tests++;
    if (bad_cmp !== 0) begin fails++; $display("FAIL de_blank_complement: got %0d bad want 0", bad_cmp); end
  endtask

  task automatic test_reset_midframe();
    int base, first_de = -1;
    while (k < 16101) step();
    tests++;
    if (v0.de !== 1'b1) begin fails++; $display("FAIL midframe_active: got de=%b want 1", v0.de); end
    reset = 1'b1;
    step();
    tests++;
    if ({v0.ce_pix, v0.de, v0.hblank, v0.vblank, v0.hs, v0.vs, v0.line_start, v0.frame_start, v0.pix_req, v0.r, v0.g, v0.b, v0.pix_x, v0.pix_y}
        !== {9'b001100000, 48'h0}) begin
      fails++;
      $display("FAIL midframe_reset_values: got %b %h", {v0.ce_pix, v0.de, v0.hblank, v0.vblank, v0.hs, v0.vs, v0.line_start, v0.frame_start, v0.pix_req},
               {v0.r, v0.g, v0.b, v0.pix_x, v0.pix_y});
    end
    reset = 1'b0;
    base = k;
    step();
    tests++;
    if ({v0.ce_pix, v0.hs} !== 2'b10) begin fails++; $display("FAIL midframe_release: got %b want 10", {v0.ce_pix, v0.hs}); end
    step();
    tests++;
    if ({v0.hs, v0.frame_start} !== 2'b11) begin fails++; $display("FAIL midframe_restart: got %b want 11", {v0.hs, v0.frame_start}); end
    while (k - base < 7800) begin
      step();
      if (v0.de && first_de < 0) first_de = k - base;
    end
    tests++;
    if (first_de !== 7738) begin fails++; $display("FAIL midframe_first_de: got %0d want 7738", first_de); end
  endtask

  task automatic test_ce_div();
    int bad_ce = 0, bad_chg = 0, hs_cnt = 0, rise1 = -1, rise2 = -1;
    logic prev_ce, prev_hs, exp_ce;
    logic [55:0] snap, prev_snap;
    do_reset();
    prev_ce = v3.ce_pix;
    prev_hs = v3.hs;
    prev_snap = {v3.hs, v3.vs, v3.hblank, v3.vblank, v3.de, v3.line_start, v3.frame_start, v3.pix_req, v3.pix_x, v3.pix_y, v3.r, v3.g, v3.b};
    while (k < 2000) begin
      step();
      exp_ce = (k >= 2) && ((k - 2) % 3 == 0);
      if (v3.ce_pix !== exp_ce) bad_ce++;
      snap = {v3.hs, v3.vs, v3.hblank, v3.vblank, v3.de, v3.line_start, v3.frame_start, v3.pix_req, v3.pix_x, v3.pix_y, v3.r, v3.g, v3.b};
      if (snap !== prev_snap && !prev_ce) bad_chg++;
      if (v3.hs && k <= 960) hs_cnt++;
      if (v3.hs && !prev_hs) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev_snap = snap;
      prev_ce = v3.ce_pix;
      prev_hs = v3.hs;
    end
    tests++;
    if (bad_ce !== 0) begin fails++; $display("FAIL ce_div3_pattern: got %0d bad want 0", bad_ce); end
    tests++;
    if (bad_chg !== 0) begin fails++; $display("FAIL ce_div3_only_on_ce: got %0d bad want 0", bad_chg); end
    tests++;
    if (rise1 !== 3) begin fails++; $display("FAIL ce_div3_hs_first: got %0d want 3", rise1); end
    tests++;
    if (rise2 - rise1 !== 960) begin fails++; $display("FAIL ce_div3_line_period: got %0d want 960", rise2 - rise1); end
    tests++;
    if (hs_cnt !== 120) begin fails++; $display("FAIL ce_div3_hs_width: got %0d want 120", hs_cnt); end
  endtask

  task automatic test_small_frame();
    int vs_cnt = 0, de_cnt = 0, hs_lo = 0, fs1 = -1, fs2 = -1, wraps = 0, bad_y = 0;
    logic [11:0] prev_y;
    vs.r_in = 3'b101;
    vs.g_in = 3'b011;
    vs.b_in = 3'b110;
    do_reset();
    prev_y = vs.pix_y;
    while (k < 600) begin
      step();
      if (k >= 2 && k <= 286) begin
        if (vs.vs) vs_cnt++;
        if (vs.de) de_cnt++;
        if (!vs.hs) hs_lo++;
      end
      if (vs.frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (vs.pix_req && vs.pix_y != prev_y) begin
        if (prev_y == 12'd7 && vs.pix_y == 12'd0) wraps++;
        else if (vs.pix_y != prev_y + 12'd1) bad_y++;
        prev_y = vs.pix_y;
      end
      if (k == 95) begin
        tests++;
        if (vs.pix_req !== 1'b0) begin fails++; $display("FAIL small_req_early: got %b want 0", vs.pix_req); end
      end
      if (k == 96) begin
        tests++;
        if ({vs.pix_req, vs.pix_x, vs.pix_y} !== {1'b1, 12'd0, 12'd0}) begin
          fails++;
          $display("FAIL small_req_linewrap: got req=%b x=%0d y=%0d want 1 0 0", vs.pix_req, vs.pix_x, vs.pix_y);
        end
      end
      if (k == 97) begin
        tests++;
        if ({vs.de, vs.r, vs.g, vs.b} !== 25'h0) begin fails++; $display("FAIL small_pre_de: got %h want 0", {vs.de, vs.r, vs.g, vs.b}); end
      end
      if (k == 98) begin
        tests++;
        if ({vs.de, vs.r, vs.g, vs.b} !== {1'b1, 24'hB66DDB}) begin
          fails++;
          $display("FAIL small_expand3: got %h want 1B66DDB", {vs.de, vs.r, vs.g, vs.b});
        end
      end
      if (k == 113) begin
        tests++;
        if ({vs.pix_req, vs.pix_x, vs.pix_y} !== {1'b0, 12'd15, 12'd0}) begin
          fails++;
          $display("FAIL small_hold: got req=%b x=%0d y=%0d want 0 15 0", vs.pix_req, vs.pix_x, vs.pix_y);
        end
      end
      if (k == 115) begin
        tests++;
        if ({vs.pix_req, vs.pix_x, vs.pix_y} !== {1'b1, 12'd0, 12'd1}) begin
          fails++;
          $display("FAIL small_y_advance: got req=%b x=%0d y=%0d want 1 0 1", vs.pix_req, vs.pix_x, vs.pix_y);
        end
      end
      if (k == 244) begin
        tests++;
        if ({vs.pix_req, vs.pix_x, vs.pix_y} !== {1'b1, 12'd15, 12'd7}) begin
          fails++;
          $display("FAIL small_last_fetch: got req=%b x=%0d y=%0d want 1 15 7", vs.pix_req, vs.pix_x, vs.pix_y);
        end
      end
    end
    tests++;
    if (vs_cnt !== 38) begin fails++; $display("FAIL small_vs_width: got %0d want 38", vs_cnt); end
    tests++;
    if (de_cnt !== 128) begin fails++; $display("FAIL small_de_count: got %0d want 128", de_cnt); end
    tests++;
    if (hs_lo !== 15) begin fails++; $display("FAIL small_hs_low_count: got %0d want 15", hs_lo); end
    tests++;
    if ({fs1, fs2} !== {32'd2, 32'd287}) begin fails++; $display("FAIL small_frame_start: got %0d,%0d want 2,287", fs1, fs2); end
    tests++;
    if ({wraps, bad_y} !== {32'd1, 32'd0}) begin fails++; $display("FAIL small_pix_y_wrap: got wraps=%0d bad=%0d want 1 0", wraps, bad_y); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    v0.r_in = 4'hA; v0.g_in = 4'h3; v0.b_in = 4'hF;
    v3.r_in = 4'h5; v3.g_in = 4'h6; v3.b_in = 4'h7;
    vs.r_in = 3'b000; vs.g_in = 3'b000; vs.b_in = 3'b000;
    test_reset();
    test_hsync();
    test_fetch_colour();
    test_reset_midframe();
    test_ce_div();
    test_small_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
